// File: rtl/clk_rst_ctrl_pkg.sv
// ============================================================================
// Module   : clk_rst_ctrl_pkg
// Brief    : Shared state encoding and phase constants for the clock/reset
//            controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package clk_rst_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   localparam logic [3:0] PH_IDLE = 4'b0000;
   localparam logic [3:0] PH_0    = 4'b0001;
   localparam logic [3:0] PH_LAST = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/clk_phase_ring.sv
// ============================================================================
// Module   : clk_phase_ring
// Brief    : 4-bit one-hot machine-cycle phase rotator with clear, load and
//            end-of-cycle boundary flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_phase_ring
   import clk_rst_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       clear,
   input  logic       load,
   output logic [3:0] ph,
   output logic       boundary
);

   // An idle ring stays idle; only a load starts it rotating.
   always_ff @(posedge clk) begin
      if (clear) begin
         ph <= PH_IDLE;
      end else if (load) begin
         ph <= PH_0;
      end else if (ph != PH_IDLE) begin
         ph <= {ph[2:0], ph[3]};
      end
   end

   assign boundary = (ph == PH_LAST);

endmodule

`default_nettype wire

// File: rtl/clk_rst_ctrl.sv
// ============================================================================
// Module   : clk_rst_ctrl
// Brief    : Oscillator warm-up / STOP / HALT controller producing OSC_STABLE,
//            SYNC_RESET and one-hot phase enables from a single fast clock.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_rst_ctrl
   import clk_rst_ctrl_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int RESET_STRETCH = 8
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       OSC_ENA,
   input  logic       CLK_ENA,
   output logic       OSC_STABLE,
   output logic       SYNC_RESET,
   output logic [3:0] PH_OSC,
   output logic [3:0] PH_CPU
);

   localparam int WCW = $clog2(STABLE_CYCLES + 1);
   localparam int SCW = $clog2(RESET_STRETCH + 1);
   localparam logic [WCW-1:0] WARM_LAST    = WCW'(STABLE_CYCLES - 1);
   localparam logic [SCW-1:0] STRETCH_LAST = SCW'(RESET_STRETCH - 1);

   state_t           state;
   logic [WCW-1:0]   warm_cnt;
   logic [SCW-1:0]   stretch_cnt;
   logic             from_reset;
   logic             osc_stable;
   logic             sync_reset;
   logic             cpu_run;
   logic [3:0]       ph_osc;
   logic             boundary;

   logic             warm_abort;
   logic             warm_done;
   logic             stop_now;
   logic             stretch_end;
   logic             sync_reset_next;
   logic             cycle_start;

   always_comb begin
      warm_abort      = (state == ST_WARMUP) && !OSC_ENA && !from_reset;
      warm_done       = (state == ST_WARMUP) && !warm_abort && (warm_cnt == WARM_LAST);
      stop_now        = (state == ST_RUN) && !sync_reset && boundary && !OSC_ENA;
      stretch_end     = (state == ST_RUN) && sync_reset && (stretch_cnt == STRETCH_LAST);
      sync_reset_next = sync_reset && !stretch_end;
      // Edges whose result is PH_OSC=0001: the only points where HALT may change.
      cycle_start     = warm_done || ((state == ST_RUN) && boundary && !stop_now);
   end

   clk_phase_ring u_ring (
      .clk      (CLK),
      .clear    (RESET || stop_now),
      .load     (!RESET && warm_done),
      .ph       (ph_osc),
      .boundary (boundary)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= ST_WARMUP;
         warm_cnt    <= '0;
         stretch_cnt <= '0;
         from_reset  <= 1'b1;
         osc_stable  <= 1'b0;
         sync_reset  <= 1'b1;
         cpu_run     <= 1'b0;
      end else begin
         sync_reset <= sync_reset_next;
         if (cycle_start) begin
            cpu_run <= sync_reset_next || CLK_ENA;
         end
         case (state)
            ST_OFF: begin
               if (OSC_ENA) begin
                  state    <= ST_WARMUP;
                  warm_cnt <= '0;
               end
            end
            ST_WARMUP: begin
               if (warm_abort) begin
                  state    <= ST_OFF;
                  warm_cnt <= '0;
               end else if (warm_done) begin
                  state      <= ST_RUN;
                  osc_stable <= 1'b1;
                  warm_cnt   <= '0;
               end else begin
                  warm_cnt <= warm_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (stretch_end) begin
                  from_reset  <= 1'b0;
                  stretch_cnt <= '0;
               end else if (sync_reset) begin
                  stretch_cnt <= stretch_cnt + 1'b1;
               end
               if (stop_now) begin
                  state      <= ST_OFF;
                  osc_stable <= 1'b0;
               end
            end
            default: begin
               state <= ST_OFF;
            end
         endcase
      end
   end

   assign OSC_STABLE = osc_stable;
   assign SYNC_RESET = sync_reset;
   assign PH_OSC     = ph_osc;
   assign PH_CPU     = cpu_run ? ph_osc : PH_IDLE;

endmodule

`default_nettype wire

// File: tb/tb_clk_rst_ctrl.sv
// ============================================================================
// Module   : tb_clk_rst_ctrl
// Brief    : Randomized self-checking bench for clk_rst_ctrl against a
//            behavioural phase/countdown model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_rst_ctrl;

   localparam int STABLE  = 16;
   localparam int STRETCH = 8;

   logic       clk = 1'b0;
   logic       rst_in;
   logic       osc_ena;
   logic       clk_ena;
   logic       osc_stable;
   logic       sync_reset;
   logic [3:0] ph_osc;
   logic [3:0] ph_cpu;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: phase index (-1 when oscillator not running), warm-up edge count.
   int m_phase;
   int m_warm;
   bit m_warming;
   bit m_fromrst;
   bit m_sres;
   int m_stretch;
   bit m_cpu;

   clk_rst_ctrl #(
      .STABLE_CYCLES (STABLE),
      .RESET_STRETCH (STRETCH)
   ) dut (
      .CLK        (clk),
      .RESET      (rst_in),
      .OSC_ENA    (osc_ena),
      .CLK_ENA    (clk_ena),
      .OSC_STABLE (osc_stable),
      .SYNC_RESET (sync_reset),
      .PH_OSC     (ph_osc),
      .PH_CPU     (ph_cpu)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
   endtask

   task automatic model_edge(input bit r, input bit oe, input bit ce);
      bit stop;
      if (r) begin
         m_phase = -1; m_warm = 0; m_warming = 1; m_fromrst = 1;
         m_sres = 1; m_stretch = 0; m_cpu = 0;
      end else if (m_warming) begin
         if (!oe && !m_fromrst) begin
            m_warming = 0; m_warm = 0;
         end else begin
            m_warm++;
            if (m_warm == STABLE) begin
               m_warming = 0; m_warm = 0; m_phase = 0;
               m_cpu = m_sres | ce;
            end
         end
      end else if (m_phase >= 0) begin
         stop = !m_sres && (m_phase == 3) && !oe;
         if (m_sres) begin
            m_stretch++;
            if (m_stretch == STRETCH) begin
               m_sres = 0; m_fromrst = 0; m_stretch = 0;
            end
         end
         if (stop) m_phase = -1;
         else begin
            m_phase = (m_phase + 1) % 4;
            if (m_phase == 0) m_cpu = m_sres | ce;
         end
      end else if (oe) begin
         m_warming = 1; m_warm = 0;
      end
   endtask

   task automatic step_and_check();
      logic [3:0] e_osc;
      @(posedge clk);
      model_edge(rst_in, osc_ena, clk_ena);
      #1;
      e_osc = (m_phase < 0) ? 4'b0000 : 4'(1 << m_phase);
      check("osc_stable", {3'b0, osc_stable}, {3'b0, (m_phase >= 0)});
      check("sync_reset", {3'b0, sync_reset}, {3'b0, m_sres});
      check("ph_osc", ph_osc, e_osc);
      check("ph_cpu", ph_cpu, m_cpu ? e_osc : 4'b0000);
   endtask

   initial begin
      int oe_hold;
      int ce_hold;
      rst_in  = 1'b1;
      osc_ena = 1'b1;
      clk_ena = 1'b1;
      m_phase = -1; m_warm = 0; m_warming = 0; m_fromrst = 0;
      m_sres = 0; m_stretch = 0; m_cpu = 0;
      repeat (3) step_and_check();
      rst_in = 1'b0;

      // Clean release with both enables high, halt early in the first run.
      for (int i = 0; i < 40; i++) begin
         clk_ena = (i >= 18 && i < 30) ? 1'b0 : 1'b1;
         osc_ena = (i >= 17 && i < 20) ? 1'b0 : 1'b1;
         step_and_check();
      end

      oe_hold = 0;
      ce_hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (oe_hold == 0) begin
            osc_ena = ($urandom_range(0, 3) != 0);
            oe_hold = osc_ena ? $urandom_range(1, 60) : $urandom_range(1, 12);
         end
         if (ce_hold == 0) begin
            clk_ena = ($urandom_range(0, 2) != 0);
            ce_hold = $urandom_range(1, 14);
         end
         oe_hold--;
         ce_hold--;
         rst_in = ($urandom_range(0, 299) == 0);
         step_and_check();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
